// File: rtl/numofbit_scan.sv
// Sequential bit-length / lowest-set-bit encoder that scans one CHUNK_WIDTH slice per cycle.
// Build option NUMBIT_FIXED_LATENCY_EN: always visit every chunk so latency is NUM_CHUNKS+1 for all inputs.
module numofbit_scan #(
    parameter int DATA_WIDTH  = 32,
    parameter int CHUNK_WIDTH = 8,
    localparam int AW = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [AW-1:0]         out_amount,
    output logic                  out_zero,
    output logic                  busy
);

    localparam int NUM_CHUNKS = DATA_WIDTH / CHUNK_WIDTH;
    localparam int IW = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam int PW = (CHUNK_WIDTH > 1) ? $clog2(CHUNK_WIDTH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CHUNKS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } stateT;

    stateT                 stateReg, stateNext;
    logic [DATA_WIDTH-1:0] dataReg, dataNext;
    logic                  modeReg, modeNext;
    logic [IW-1:0]         idxReg, idxNext;
    logic [AW-1:0]         amountReg, amountNext;
    logic                  zeroReg, zeroNext;
`ifdef NUMBIT_FIXED_LATENCY_EN
    logic                  foundReg, foundNext;
`endif

    logic [CHUNK_WIDTH-1:0] chunkArr [NUM_CHUNKS];
    logic [CHUNK_WIDTH-1:0] chunkCur;
    logic [PW-1:0]          hiPos;
    logic [PW-1:0]          loPos;
    logic [PW-1:0]          localPos;
    logic                   chunkNonZero;
    logic                   lastChunk;
    logic [AW-1:0]          hitAmount;
    logic [IW-1:0]          idxStep;

    generate
        for (genvar gi = 0; gi < NUM_CHUNKS; gi++) begin : gChunk
            assign chunkArr[gi] = dataReg[gi*CHUNK_WIDTH +: CHUNK_WIDTH];
        end
    endgenerate

    // Only a CHUNK_WIDTH-wide priority search sits on the per-cycle path.
    always_comb begin
        chunkCur = chunkArr[idxReg];
        hiPos    = '0;
        loPos    = '0;
        for (int i = 0; i < CHUNK_WIDTH; i++) begin
            if (chunkCur[i]) begin
                hiPos = PW'(i);
            end
        end
        for (int i = CHUNK_WIDTH - 1; i >= 0; i--) begin
            if (chunkCur[i]) begin
                loPos = PW'(i);
            end
        end
        chunkNonZero = |chunkCur;
        localPos     = modeReg ? loPos : hiPos;
        hitAmount    = AW'(idxReg) * AW'(CHUNK_WIDTH) + AW'(localPos) + AW'(1);
        lastChunk    = modeReg ? (idxReg == LAST_IDX) : (idxReg == '0);
        idxStep      = modeReg ? (idxReg + IW'(1)) : (idxReg - IW'(1));
    end

    always_comb begin
        stateNext  = stateReg;
        dataNext   = dataReg;
        modeNext   = modeReg;
        idxNext    = idxReg;
        amountNext = amountReg;
        zeroNext   = zeroReg;
`ifdef NUMBIT_FIXED_LATENCY_EN
        foundNext  = foundReg;
`endif
        case (stateReg)
            IDLE: begin
                if (in_valid) begin
                    stateNext = SCAN;
                    dataNext  = in_data;
                    modeNext  = in_mode;
                    idxNext   = in_mode ? '0 : LAST_IDX;
`ifdef NUMBIT_FIXED_LATENCY_EN
                    foundNext = 1'b0;
`endif
                end
            end
            SCAN: begin
`ifdef NUMBIT_FIXED_LATENCY_EN
                // First hit in scan order wins; remaining chunks are visited only to fix latency.
                if (!foundReg && chunkNonZero) begin
                    amountNext = hitAmount;
                    zeroNext   = 1'b0;
                    foundNext  = 1'b1;
                end
                if (lastChunk) begin
                    stateNext = DONE;
                    if (!foundReg && !chunkNonZero) begin
                        amountNext = '0;
                        zeroNext   = 1'b1;
                    end
                end else begin
                    idxNext = idxStep;
                end
`else
                if (chunkNonZero) begin
                    amountNext = hitAmount;
                    zeroNext   = 1'b0;
                    stateNext  = DONE;
                end else if (lastChunk) begin
                    amountNext = '0;
                    zeroNext   = 1'b1;
                    stateNext  = DONE;
                end else begin
                    idxNext = idxStep;
                end
`endif
            end
            DONE: begin
                if (out_ready) begin
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stateReg  <= IDLE;
            dataReg   <= '0;
            modeReg   <= 1'b0;
            idxReg    <= '0;
            amountReg <= '0;
            zeroReg   <= 1'b0;
`ifdef NUMBIT_FIXED_LATENCY_EN
            foundReg  <= 1'b0;
`endif
        end else begin
            stateReg  <= stateNext;
            dataReg   <= dataNext;
            modeReg   <= modeNext;
            idxReg    <= idxNext;
            amountReg <= amountNext;
            zeroReg   <= zeroNext;
`ifdef NUMBIT_FIXED_LATENCY_EN
            foundReg  <= foundNext;
`endif
        end
    end

    assign in_ready   = (stateReg == IDLE);
    assign out_valid  = (stateReg == DONE);
    assign busy       = (stateReg != IDLE);
    assign out_amount = amountReg;
    assign out_zero   = zeroReg;

endmodule
